// File: rtl/regfile_wb_sched_if.sv
// Writeback-scheduler bus: two writeback sources, the issue query, and the regfile write port.
// master drives sources/issue (pipeline side); slave is the scheduler.
interface regfile_wb_sched_if #(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 32
);
  localparam int unsigned IdxW = $clog2(els_p);
  localparam int unsigned CntW = IdxW + 1;

  logic                src0_v_i;
  logic [IdxW-1:0]     src0_rd_i;
  logic [width_p-1:0]  src0_data_i;
  logic                src0_ready_o;

  logic                src1_v_i;
  logic [IdxW-1:0]     src1_rd_i;
  logic [width_p-1:0]  src1_data_i;
  logic                src1_ready_o;

  logic                issue_v_i;
  logic [IdxW-1:0]     issue_rs1_i;
  logic [IdxW-1:0]     issue_rs2_i;
  logic [IdxW-1:0]     issue_rd_i;
  logic                issue_wr_i;
  logic                issue_stall_o;

  logic                rd_w_v_o;
  logic [IdxW-1:0]     rd_o;
  logic [width_p-1:0]  rd_data_o;
  logic [CntW-1:0]     pending_o;

  modport master (
    output src0_v_i, src0_rd_i, src0_data_i,
    input  src0_ready_o,
    output src1_v_i, src1_rd_i, src1_data_i,
    input  src1_ready_o,
    output issue_v_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_wr_i,
    input  issue_stall_o,
    input  rd_w_v_o, rd_o, rd_data_o, pending_o
  );

  modport slave (
    input  src0_v_i, src0_rd_i, src0_data_i,
    output src0_ready_o,
    input  src1_v_i, src1_rd_i, src1_data_i,
    output src1_ready_o,
    input  issue_v_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_wr_i,
    output issue_stall_o,
    output rd_w_v_o, rd_o, rd_data_o, pending_o
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin writeback arbiter with a one-entry writeback stage and a register busy scoreboard
// that stalls issue on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  regfile_wb_sched_if.slave bus
);
  localparam int unsigned IdxW = $clog2(els_p);
  localparam int unsigned CntW = IdxW + 1;

  // rr_q: 0 = src0 wins the next contention, 1 = src1
  logic                rr_q, rr_d;
  logic                wb_v_q, wb_v_d;
  logic [IdxW-1:0]     wb_rd_q, wb_rd_d;
  logic [width_p-1:0]  wb_data_q, wb_data_d;
  logic [els_p-1:0]    busy_q, busy_d;
  logic [CntW-1:0]     pending_q, pending_d;

  logic                grant0, grant1;
  logic [IdxW-1:0]     sel_rd;
  logic [width_p-1:0]  sel_data;
  logic [els_p-1:0]    wr_mask;
  logic [els_p-1:0]    hz_vec;
  logic                stall;
  logic                issue_fire;
  logic                set_busy;

  // Arbitration
  always_comb begin
    grant0 = bus.src0_v_i & (~bus.src1_v_i | ~rr_q);
    grant1 = bus.src1_v_i & (~bus.src0_v_i | rr_q);
    rr_d   = rr_q;
    if (bus.src0_v_i && bus.src1_v_i) begin
      rr_d = ~rr_q;
    end
    sel_rd   = grant1 ? bus.src1_rd_i   : bus.src0_rd_i;
    sel_data = grant1 ? bus.src1_data_i : bus.src0_data_i;
  end

  // Writeback stage; writes to x0 are accepted but never reach the port
  always_comb begin
    wb_v_d    = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (grant0 || grant1) begin
      wb_v_d    = (sel_rd != '0);
      wb_rd_d   = sel_rd;
      wb_data_d = sel_data;
    end
  end

  // The regfile forwards same-cycle write data, so the register being written is not a hazard
  always_comb begin
    wr_mask = '0;
    if (wb_v_q) begin
      wr_mask[wb_rd_q] = 1'b1;
    end
    hz_vec = busy_q & ~wr_mask;
  end

  always_comb begin
    stall = ~rst_i;
    if (bus.issue_v_i) begin
      if (hz_vec[bus.issue_rs1_i] || hz_vec[bus.issue_rs2_i] ||
          (bus.issue_wr_i && hz_vec[bus.issue_rd_i])) begin
        stall = 1'b1;
      end
    end
    issue_fire = bus.issue_v_i & ~stall;
    set_busy   = issue_fire & bus.issue_wr_i & (bus.issue_rd_i != '0);
  end

  // Scoreboard: clear first so a same-cycle set of the same index wins
  always_comb begin
    busy_d = busy_q;
    if (wb_v_q) begin
      busy_d[wb_rd_q] = 1'b0;
    end
    if (set_busy) begin
      busy_d[bus.issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pending_d = '0;
    for (int i = 0; i < int'(els_p); i++) begin
      pending_d = pending_d + CntW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_q      <= 1'b0;
      wb_v_q    <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wb_v_q    <= wb_v_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign bus.src0_ready_o  = grant0 & rst_i;
  assign bus.src1_ready_o  = grant1 & rst_i;
  assign bus.issue_stall_o = stall;
  assign bus.rd_w_v_o      = wb_v_q;
  assign bus.rd_o          = wb_rd_q;
  assign bus.rd_data_o     = wb_data_q;
  assign bus.pending_o     = pending_q;

endmodule
